// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX_ONES = 4'd9;
    localparam bcd_t BCD_MAX_TENS = 4'd5;

    function automatic logic bcd_in_range(input bcd_t d, input bcd_t max_val);
        return d <= max_val;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> MAX and raises borrow on that step.
module bcd_down_digit
    import countdown_timer_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX_ONES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       dec_en,
    output logic [3:0] digit,
    output logic       borrow
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_digit;
        end else if (dec_en) begin
            digit_d = (digit_q == 4'd0) ? MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign borrow = dec_en && (digit_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown timer with load/start/stop control and a done pulse.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [3:0] load_min_tens,
    input  logic [3:0] load_min_ones,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_sec_ones,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       load_err
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic          load_err_q, load_err_d;

    // Digit index 0 = sec_ones ... 3 = min_tens; borrow ripples upward.
    logic [3:0][3:0] cur_digits;
    logic [3:0][3:0] load_digits;
    logic [3:0]      dec_chain;
    logic [3:0]      borrow_chain;

    logic load_ok, load_en, tick, reach_zero, count_zero;

    assign load_digits = {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones};
    assign load_ok = bcd_in_range(load_sec_ones, BCD_MAX_ONES) &&
                     bcd_in_range(load_sec_tens, BCD_MAX_TENS) &&
                     bcd_in_range(load_min_ones, BCD_MAX_ONES) &&
                     bcd_in_range(load_min_tens, BCD_MAX_TENS);
    assign load_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign load_en    = load_valid && load_ready && load_ok;
    assign count_zero = (cur_digits == '0);
    assign tick       = (state_q == ST_RUN) && !stop && (presc_q == PRESC_LAST);
    // A borrow out of the top digit would mean decrementing 00:00; treat it as finished.
    assign reach_zero = tick && ((cur_digits == 16'h0001) || borrow_chain[3]);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            if (gi == 0) begin : g_first
                assign dec_chain[gi] = tick;
            end else begin : g_rest
                assign dec_chain[gi] = borrow_chain[gi-1];
            end
            bcd_down_digit #(
                .MAX((gi % 2 == 1) ? BCD_MAX_TENS : BCD_MAX_ONES)
            ) u_digit (
                .clk       (clk),
                .reset     (reset),
                .load      (load_en),
                .load_digit(load_digits[gi]),
                .dec_en    (dec_chain[gi]),
                .digit     (cur_digits[gi]),
                .borrow    (borrow_chain[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        done_d     = 1'b0;
        load_err_d = load_valid && load_ready && !load_ok;
        case (state_q)
            ST_IDLE: begin
                if (!load_en && start && !stop) begin
                    if (count_zero) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    presc_d = '0;
                    if (reach_zero) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (load_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            running_q  <= running_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign sec_ones = cur_digits[0];
    assign sec_tens = cur_digits[1];
    assign min_ones = cur_digits[2];
    assign min_tens = cur_digits[3];
    assign running  = running_q;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: stimulus queues expected snapshots and pulses, a negedge monitor checks them.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid, load_ready;
    logic [3:0] load_min_tens, load_min_ones, load_sec_tens, load_sec_ones;
    logic       start, stop;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done, load_err;

    countdown_timer #(.TICK_DIV(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_min_tens(load_min_tens),
        .load_min_ones(load_min_ones),
        .load_sec_tens(load_sec_tens),
        .load_sec_ones(load_sec_ones),
        .start        (start),
        .stop         (stop),
        .min_tens     (min_tens),
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .running      (running),
        .done         (done),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] digits;
        logic        run;
        logic        rdy;
    } exp_t;

    exp_t snap_q[$];
    int   done_exp[$];
    int   err_exp[$];
    int   edge_n = 0;
    int   total  = 0;
    int   bad    = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: compares whatever is due at this edge, and every done/load_err pulse.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] got;
        got = {min_tens, min_ones, sec_tens, sec_ones};
        while (snap_q.size() > 0 && snap_q[0].cyc <= edge_n) begin
            e = snap_q.pop_front();
            total++;
            if (e.cyc < edge_n) begin
                bad++;
                $display("FAIL %s: check for edge %0d skipped (now %0d)", e.name, e.cyc, edge_n);
            end else if (got !== e.digits || running !== e.run || load_ready !== e.rdy) begin
                bad++;
                $display("FAIL %s: got %h run=%b rdy=%b, required %h run=%b rdy=%b",
                         e.name, got, running, load_ready, e.digits, e.run, e.rdy);
            end else begin
                $display("ok   %s @%0d: %h run=%b rdy=%b", e.name, edge_n, got, running, load_ready);
            end
        end
        if (done !== 1'b0) begin
            total++;
            if (done_exp.size() > 0 && done_exp[0] == edge_n) begin
                void'(done_exp.pop_front());
                $display("ok   done pulse @%0d", edge_n);
            end else begin
                bad++;
                $display("FAIL done_pulse: got done=%b at edge %0d, required 0", done, edge_n);
            end
        end
        while (done_exp.size() > 0 && done_exp[0] < edge_n) begin
            total++;
            bad++;
            $display("FAIL done_pulse: got 0 at edge %0d, required 1", done_exp.pop_front());
        end
        if (load_err !== 1'b0) begin
            total++;
            if (err_exp.size() > 0 && err_exp[0] == edge_n) begin
                void'(err_exp.pop_front());
                $display("ok   load_err pulse @%0d", edge_n);
            end else begin
                bad++;
                $display("FAIL load_err: got %b at edge %0d, required 0", load_err, edge_n);
            end
        end
        while (err_exp.size() > 0 && err_exp[0] < edge_n) begin
            total++;
            bad++;
            $display("FAIL load_err: got 0 at edge %0d, required 1", err_exp.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) step();
    endtask

    task automatic expect_at(input string n, input int c, input logic [15:0] d,
                             input logic r, input logic rdy);
        exp_t e;
        e.cyc = c; e.name = n; e.digits = d; e.run = r; e.rdy = rdy;
        snap_q.push_back(e);
    endtask

    task automatic do_load(input logic [15:0] d, input logic with_start);
        load_valid = 1'b1;
        {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = d;
        start = with_start;
        step();
        load_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic p);
        start = s;
        stop  = p;
        step();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, r, e;
        reset = 1'b1; load_valid = 1'b0; start = 1'b0; stop = 1'b0;
        {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        expect_at("reset_state", edge_n, 16'h0000, 1'b0, 1'b1);
        step();
        reset = 1'b0;
        expect_at("after_release", edge_n, 16'h0000, 1'b0, 1'b1);

        // 00:01 counts down to done after exactly TICK_DIV edges.
        do_load(16'h0001, 1'b0); e = edge_n;
        expect_at("load_0001", e, 16'h0001, 1'b0, 1'b1);
        pulse(1'b1, 1'b0); s = edge_n;
        expect_at("running_c1", s, 16'h0001, 1'b1, 1'b0);
        expect_at("pre_tick", s + 9, 16'h0001, 1'b1, 1'b0);
        expect_at("reach_zero", s + 10, 16'h0000, 1'b0, 1'b1);
        done_exp.push_back(s + 10);
        expect_at("done_hold", s + 11, 16'h0000, 1'b0, 1'b1);
        wait_edges(11);
        pulse(1'b1, 1'b0);
        expect_at("start_in_done", edge_n, 16'h0000, 1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        expect_at("stop_in_done", edge_n, 16'h0000, 1'b0, 1'b1);

        // Borrow chains 10:00 -> 09:59 and 01:00 -> 00:59.
        do_load(16'h1000, 1'b0); e = edge_n;
        expect_at("load_1000", e, 16'h1000, 1'b0, 1'b1);
        pulse(1'b1, 1'b0); s = edge_n;
        expect_at("run_1000", s, 16'h1000, 1'b1, 1'b0);
        expect_at("pre_1000", s + 9, 16'h1000, 1'b1, 1'b0);
        expect_at("tick_0959", s + 10, 16'h0959, 1'b1, 1'b0);
        wait_edges(10);
        pulse(1'b0, 1'b1);
        expect_at("pause_0959", edge_n, 16'h0959, 1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        expect_at("idle_0959", edge_n, 16'h0959, 1'b0, 1'b1);
        do_load(16'h0100, 1'b0); e = edge_n;
        expect_at("load_0100", e, 16'h0100, 1'b0, 1'b1);
        pulse(1'b1, 1'b0); s = edge_n;
        expect_at("tick_0059", s + 10, 16'h0059, 1'b1, 1'b0);
        wait_edges(10);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        expect_at("idle_0059", edge_n, 16'h0059, 1'b0, 1'b1);

        // Out-of-range loads are rejected; 59:59 is the largest legal load.
        do_load(16'h0A00, 1'b0);
        expect_at("rej_0A00", edge_n, 16'h0059, 1'b0, 1'b1); err_exp.push_back(edge_n);
        do_load(16'h0060, 1'b0);
        expect_at("rej_0060", edge_n, 16'h0059, 1'b0, 1'b1); err_exp.push_back(edge_n);
        do_load(16'h6000, 1'b0);
        expect_at("rej_6000", edge_n, 16'h0059, 1'b0, 1'b1); err_exp.push_back(edge_n);
        do_load(16'h5959, 1'b0);
        expect_at("load_5959", edge_n, 16'h5959, 1'b0, 1'b1);

        // Pause keeps the prescaler: resume decrements 7 edges later.
        do_load(16'h0005, 1'b0);
        pulse(1'b1, 1'b0); s = edge_n;
        expect_at("tick_0004", s + 10, 16'h0004, 1'b1, 1'b0);
        wait_edges(13);
        pulse(1'b0, 1'b1);
        expect_at("pause_0004", s + 14, 16'h0004, 1'b0, 1'b0);
        wait_edges(3);
        expect_at("pause_hold", edge_n, 16'h0004, 1'b0, 1'b0);
        pulse(1'b1, 1'b0); r = edge_n;
        expect_at("resume", r, 16'h0004, 1'b1, 1'b0);
        do_load(16'h0AA0, 1'b0);
        expect_at("load_in_run", r + 1, 16'h0004, 1'b1, 1'b0);
        expect_at("resume_pre", r + 6, 16'h0004, 1'b1, 1'b0);
        expect_at("resume_tick", r + 7, 16'h0003, 1'b1, 1'b0);
        wait_edges(6);
        pulse(1'b1, 1'b1);
        expect_at("both_in_run", edge_n, 16'h0003, 1'b0, 1'b0);
        pulse(1'b1, 1'b1);
        expect_at("both_in_pause", edge_n, 16'h0003, 1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        expect_at("both_in_idle", edge_n, 16'h0003, 1'b0, 1'b1);
        step();
        expect_at("idle_stays", edge_n, 16'h0003, 1'b0, 1'b1);
        do_load(16'h0002, 1'b1);
        expect_at("load_and_start", edge_n, 16'h0002, 1'b0, 1'b1);
        step();
        expect_at("load_start_idle", edge_n, 16'h0002, 1'b0, 1'b1);

        // Asynchronous reset mid-run, then start at 00:00 finishes immediately.
        do_load(16'h0003, 1'b0);
        pulse(1'b1, 1'b0); s = edge_n;
        expect_at("run_0003", s + 4, 16'h0003, 1'b1, 1'b0);
        wait_edges(5);
        reset = 1'b1;
        expect_at("reset_mid_run", edge_n, 16'h0000, 1'b0, 1'b1);
        wait_edges(2);
        reset = 1'b0;
        expect_at("reset_released", edge_n, 16'h0000, 1'b0, 1'b1);
        pulse(1'b1, 1'b0); s = edge_n;
        expect_at("start_at_zero", s, 16'h0000, 1'b0, 1'b1);
        done_exp.push_back(s);
        step();
        expect_at("after_zero_start", edge_n, 16'h0000, 1'b0, 1'b1);

        wait_edges(3);
        if (snap_q.size() != 0 || done_exp.size() != 0 || err_exp.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d/%0d/%0d pending checks, required 0/0/0",
                     snap_q.size(), done_exp.size(), err_exp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
